mac_seq_ctrl: RTL and testbench

Sequencer for a single signed multiply-accumulate unit. It accepts a job length, clears the accumulator, and streams exactly that many operand pairs into the MAC under a valid/ready handshake. It then captures the final accumulator value and presents it on a valid/ready result port. It sits between the operand buffer/stream logic and one MAC instance in the matrix datapath.

---
 rtl/mac_ctrl_pkg.sv | 8 +
 rtl/mac_len_cnt.sv | 19 +
 rtl/mac_seq_ctrl.sv | 73 +++++++
 tb/tb_mac_seq_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg: shared widths and FSM state encoding for the MAC sequencer
// Ports: none (package)
package mac_ctrl_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W = 32;
  localparam int DEF_LEN_W = 8;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPTURE, OUT} state_e;
endpackage

// File: rtl/mac_len_cnt.sv
// mac_len_cnt: loadable down-counter tracking operand pairs still owed to the MAC
// Ports: clk, rst (sync, high) | load, load_val -> preset | dec -> count down | cnt, last (cnt==1)
module mac_len_cnt #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             dec,
  output logic [LEN_W-1:0] cnt,
  output logic             last
);
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec) cnt <= cnt - 1'b1;
  assign last = cnt == LEN_W'(1);
endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one MAC job (clear, stream len operand pairs, capture, hand off result)
// Ports: clk, rst (sync, high) | start, len, busy -> job control
//        in_valid, in_ready, in_a, in_b -> operand stream
//        mac_clear, mac_en, mac_a, mac_b, mac_acc -> MAC interface
//        out_valid, out_ready, out_data -> result port
module mac_seq_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              mac_clear,
  output logic              mac_en,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data
);
  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_CLEAR = CLEAR;
  localparam logic [2:0] S_RUN = RUN;
  localparam logic [2:0] S_CAPTURE = CAPTURE;
  localparam logic [2:0] S_OUT = OUT;
  logic [2:0] state, state_nxt;
  logic [LEN_W-1:0] cnt;
  logic last, beat;
  mac_len_cnt #(.LEN_W(LEN_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .load(state == S_IDLE && start),
    .load_val(len),
    .dec(beat),
    .cnt(cnt),
    .last(last)
  );
  // handshake outputs decode state only, so in_valid never reaches in_ready
  assign in_ready = state == S_RUN;
  assign beat = in_ready && in_valid;
  assign mac_en = beat;
  assign mac_clear = state == S_CLEAR;
  assign busy = state != S_IDLE;
  assign out_valid = state == S_OUT;
  assign mac_a = in_a;
  assign mac_b = in_b;
  always_comb begin
    state_nxt = state == S_IDLE    ? (start ? S_CLEAR : S_IDLE)
              : state == S_CLEAR   ? (cnt != '0 ? S_RUN : S_CAPTURE)
              : state == S_RUN     ? (beat && last ? S_CAPTURE : S_RUN)
              : state == S_CAPTURE ? S_OUT
              : state == S_OUT     ? (out_ready ? S_IDLE : S_OUT)
              : S_IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_CAPTURE) out_data <= mac_acc;
    end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: table-driven check of mac_seq_ctrl against behavioural 32- and 16-bit MACs
module tb_mac_seq_ctrl;
  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready;
  logic [7:0] len_i, in_a, in_b;
  logic busy, in_ready, mac_clear, mac_en, out_valid;
  logic [7:0] mac_a, mac_b;
  logic [31:0] out_data;
  logic busy16, in_ready16, mac_clear16, mac_en16, out_valid16;
  logic [7:0] mac_a16, mac_b16;
  logic [15:0] out16;
  logic signed [31:0] acc = 32'sd1234;
  logic signed [15:0] acc16 = 16'sd999;
  int compared = 0, mismatched = 0, en_cnt = 0, clr_cnt = 0;

  always #5 clk = ~clk;

  mac_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .len(len_i), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_clear(mac_clear), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
    .mac_acc(acc), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  mac_seq_ctrl #(.ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .len(len_i), .busy(busy16),
    .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
    .mac_clear(mac_clear16), .mac_en(mac_en16), .mac_a(mac_a16), .mac_b(mac_b16),
    .mac_acc(acc16), .out_valid(out_valid16), .out_ready(out_ready), .out_data(out16)
  );

  // reference MACs: not reset, so only CLEAR can zero them
  always @(posedge clk) begin
    if (mac_clear) acc <= 32'sd0;
    else if (mac_en) acc <= acc + $signed(mac_a) * $signed(mac_b);
    if (mac_clear16) acc16 <= 16'sd0;
    else if (mac_en16) acc16 <= acc16 + $signed(mac_a16) * $signed(mac_b16);
    en_cnt <= en_cnt + int'(mac_en);
    clr_cnt <= clr_cnt + int'(mac_clear);
  end

  typedef struct {
    logic [7:0] len;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    bit toggle;
    int hold;
    int exp32;
    int exp16;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input longint act, input longint exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_job(input vec_t v);
    int span, e, o, idx, en0, clr0;
    bit ee;
    span = v.len == 0 ? 0 : (v.toggle ? 2 * int'(v.len) - 1 : int'(v.len));
    e = span + 3;
    start = 1'b1;
    len_i = v.len;
    in_valid = 1'b0;
    out_ready = v.hold == 0;
    @(negedge clk);
    chk("idle_before_start", busy, 0);
    en0 = en_cnt;
    clr0 = clr_cnt;
    @(posedge clk); #1;
    for (int c = 1; c <= e + v.hold; c++) begin
      o = c - 2;
      ee = o >= 0 && o < span && (!v.toggle || o % 2 == 0);
      idx = v.toggle ? o / 2 : o;
      start = (c >= e && c < e + v.hold) || (o >= 0 && o < span);
      in_valid = !(o >= 0 && o < span && v.toggle && o % 2 == 1);
      in_a = ee ? v.a[idx] : 8'd55;
      in_b = ee ? v.b[idx] : 8'd55;
      out_ready = v.hold == 0 || c >= e + v.hold;
      @(negedge clk);
      chk("mac_en", mac_en, ee);
      chk("mac_clear", mac_clear, c == 1);
      chk("in_ready", in_ready, o >= 0 && o < span);
      chk("busy", busy, 1);
      chk("out_valid", out_valid, c >= e);
      chk("mac_a", mac_a, in_a);
      chk("mac_b", mac_b, in_b);
      if (c >= e) begin
        chk("out_data", $signed(out_data), v.exp32);
        chk("out_data16", $signed(out16), v.exp16);
      end
      @(posedge clk); #1;
    end
    chk("mac_en_pulses", en_cnt - en0, v.len);
    chk("mac_clear_pulses", clr_cnt - clr0, 1);
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'd3, {8'd0, 8'd7, 8'(-4), 8'd2}, {8'd0, 8'(-1), 8'd5, 8'd3}, 1'b0, 0, -21, -21};
    vecs[1] = '{8'd4, {8'd1, 8'd1, 8'd1, 8'd1}, {8'd1, 8'd1, 8'd1, 8'd1}, 1'b1, 0, 4, 4};
    vecs[2] = '{8'd0, 32'd0, 32'd0, 1'b0, 0, 0, 0};
    vecs[3] = '{8'd2, {8'd0, 8'd0, 8'd10, 8'd10}, {8'd0, 8'd0, 8'd10, 8'd10}, 1'b0, 5, 200, 200};
    vecs[4] = '{8'd3, {8'd0, 8'd127, 8'd127, 8'd127}, {8'd0, 8'd127, 8'd127, 8'd127}, 1'b0, 0, 48387, -17149};
    vecs[5] = '{8'd4, {8'd0, 8'(-1), 8'd127, 8'(-128)}, {8'd5, 8'(-1), 8'(-128), 8'd127}, 1'b1, 1, -32511, -32511};
    rst = 1'b1;
    start = 1'b0;
    len_i = 8'd0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_a = 8'(-5);
    in_b = 8'd9;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mac_en", mac_en, 0);
    chk("rst_mac_clear", mac_clear, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_mac_a", mac_a, 8'hFB);
    chk("rst_mac_b", mac_b, 8'd9);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) run_job(vecs[i]);
    @(negedge clk);
    chk("idle_after_table", busy, 0);
    @(posedge clk); #1;
    start = 1'b1;
    len_i = 8'd3;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_a = 8'd2;
    in_b = 8'd3;
    @(negedge clk);
    chk("abort_beat", mac_en, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy_during_rst", busy, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_acc_kept", acc, 6);
    @(posedge clk); #1;
    run_job('{8'd1, {8'd0, 8'd0, 8'd0, 8'(-128)}, {8'd0, 8'd0, 8'd0, 8'(-128)}, 1'b0, 0, 16384, 16384});
    @(negedge clk);
    chk("idle_final", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
